// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter (with helper mux_4to1)
// Brief    : Round-robin arbiter sharing one 4:1 datapath select between four
//            valid/ready requesters, feeding a single-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// mux_4to1 : plain Size-wide 4:1 word selector
// ----------------------------------------------------------------------------
module mux_4to1 #(
    parameter int Size = 64
) (
    input  logic [1:0]      sel,
    input  logic [Size-1:0] d0,
    input  logic [Size-1:0] d1,
    input  logic [Size-1:0] d2,
    input  logic [Size-1:0] d3,
    output logic [Size-1:0] y
);

    // Select one of the four input words
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// mux4_rr_arbiter : top level
// ----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int Size = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      req_valid,
    input  logic [Size-1:0] req_data0,
    input  logic [Size-1:0] req_data1,
    input  logic [Size-1:0] req_data2,
    input  logic [Size-1:0] req_data3,
    output logic [3:0]      req_ready,
    output logic [1:0]      sel_o,
    output logic            out_valid,
    output logic [Size-1:0] out_data,
    output logic [1:0]      out_src,
    input  logic            out_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      last;
    logic [1:0]      winner;
    logic [1:0]      scan_idx;
    logic            found;
    logic            any_req;
    logic            load;
    logic [Size-1:0] mux_y;

    assign any_req = |req_valid;

    // Reset gates load so no handshake can complete on a reset edge
    assign load      = reset_n & any_req & ((state == EMPTY) | out_ready);
    assign sel_o     = any_req ? winner : last;
    assign req_ready = load ? (4'b0001 << winner) : 4'b0000;
    assign out_valid = (state == FULL);

    // Round-robin scan starting just after the most recent grant
    always_comb begin
        winner   = last;
        scan_idx = last;
        found    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last + 2'(k);
            if (!found && req_valid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    mux_4to1 #(
        .Size (Size)
    ) u_mux (
        .sel (sel_o),
        .d0  (req_data0),
        .d1  (req_data1),
        .d2  (req_data2),
        .d3  (req_data3),
        .y   (mux_y)
    );

    // Buffer next-state: refill wins over drain, so a drain+fill stays FULL
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // Buffer state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output word, source index and last-grant pointer; held unless loading
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data <= '0;
            out_src  <= 2'd0;
            last     <= 2'd3;
        end else if (load) begin
            out_data <= mux_y;
            out_src  <= winner;
            last     <= winner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Directed-vector bench for mux4_rr_arbiter plus a short
//            randomized handshake stream with ordering/fairness checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int Size = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      req_valid;
    logic [Size-1:0] req_data0, req_data1, req_data2, req_data3;
    logic [3:0]      req_ready;
    logic [1:0]      sel_o;
    logic            out_valid;
    logic [Size-1:0] out_data;
    logic [1:0]      out_src;
    logic            out_ready;

    int total = 0;
    int bad   = 0;

    mux4_rr_arbiter #(.Size(Size)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_ready (req_ready),
        .sel_o     (sel_o),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after an input change
    task automatic settle();
        #1;
    endtask

    logic [63:0] rdata [4];
    int          waits [4];
    logic [3:0]  rr;
    logic        loaded;
    logic [1:0]  gsrc;
    logic [63:0] gdata;
    logic        drain_only;

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data0 = 64'hA0;
        req_data1 = 64'hA1;
        req_data2 = 64'hA2;
        req_data3 = 64'hA3;
        out_ready = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_src", {62'd0, out_src}, 64'd0);
        check("rst_sel_last", {62'd0, sel_o}, 64'd3);
        req_valid = 4'b1111;
        settle();
        check("rst_ready_gated", {60'd0, req_ready}, 64'd0);

        // ---- test 1: full request, grants 0,1,2,3,0 ----
        reset_n   = 1'b1;
        out_ready = 1'b1;
        settle();
        for (int i = 0; i < 5; i++) begin
            check("t1_ready", {60'd0, req_ready}, 64'd1 << (i % 4));
            check("t1_sel", {62'd0, sel_o}, 64'(i % 4));
            tick();
            check("t1_valid", {63'd0, out_valid}, 64'd1);
            check("t1_data", out_data, 64'hA0 + 64'(i % 4));
            check("t1_src", {62'd0, out_src}, 64'(i % 4));
        end

        // ---- test 2: advance to a grant on 2, then 0101 -> 0 then 2 ----
        check("t2_ready1", {60'd0, req_ready}, 64'b0010);
        tick();
        check("t2_ready2", {60'd0, req_ready}, 64'b0100);
        tick();
        check("t2_src_pre", {62'd0, out_src}, 64'd2);
        req_valid = 4'b0101;
        settle();
        check("t2_ready_a", {60'd0, req_ready}, 64'b0001);
        tick();
        check("t2_src_a", {62'd0, out_src}, 64'd0);
        check("t2_ready_b", {60'd0, req_ready}, 64'b0100);
        tick();
        check("t2_src_b", {62'd0, out_src}, 64'd2);

        // ---- test 3: stall with 0x55 from src 1 ----
        req_valid = 4'b0010;
        req_data1 = 64'h55;
        tick();
        check("t3_data55", out_data, 64'h55);
        check("t3_src1", {62'd0, out_src}, 64'd1);
        req_valid = 4'b1000;
        req_data3 = 64'h77;
        out_ready = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_ready", {60'd0, req_ready}, 64'd0);
            tick();
            check("t3_stall_data", out_data, 64'h55);
            check("t3_stall_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        settle();
        check("t3_release_ready", {60'd0, req_ready}, 64'b1000);
        tick();
        check("t3_data3", out_data, 64'h77);
        check("t3_src3", {62'd0, out_src}, 64'd3);

        // ---- test 4: single word then drain to EMPTY ----
        req_valid = 4'b0010;
        req_data1 = 64'h1234;
        settle();
        check("t4_ready", {60'd0, req_ready}, 64'b0010);
        tick();
        req_valid = 4'b0000;
        check("t4_valid", {63'd0, out_valid}, 64'd1);
        check("t4_data", out_data, 64'h1234);
        settle();
        check("t4_idle_ready", {60'd0, req_ready}, 64'd0);
        tick();
        check("t4_empty", {63'd0, out_valid}, 64'd0);
        check("t4_hold_data", out_data, 64'h1234);
        tick();
        check("t4_empty2", {63'd0, out_valid}, 64'd0);

        // ---- test 5: reset while FULL and stalled ----
        req_valid = 4'b0100;
        req_data2 = 64'h99;
        tick();
        check("t5_full", {63'd0, out_valid}, 64'd1);
        req_valid = 4'b1111;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        settle();
        check("t5_rst_ready", {60'd0, req_ready}, 64'd0);
        tick();
        check("t5_valid", {63'd0, out_valid}, 64'd0);
        check("t5_data", out_data, 64'd0);
        check("t5_src", {62'd0, out_src}, 64'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        settle();
        check("t5_first_ready", {60'd0, req_ready}, 64'b0001);
        tick();
        check("t5_first_src", {62'd0, out_src}, 64'd0);
        check("t5_first_data", out_data, 64'hA0);

        // ---- test 6: randomized stream with requester rule honoured ----
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0;
            rdata[i] = {$urandom, $urandom};
        end
        req_valid = 4'($urandom);
        for (int c = 0; c < 3000; c++) begin
            req_data0 = rdata[0];
            req_data1 = rdata[1];
            req_data2 = rdata[2];
            req_data3 = rdata[3];
            out_ready = ($urandom_range(0, 3) != 0);
            settle();
            rr = req_ready;
            check("r_onehot", {63'd0, ($countones(rr) <= 1)}, 64'd1);
            check("r_ready_valid", {60'd0, rr & ~req_valid}, 64'd0);
            loaded     = (rr != 4'b0000);
            drain_only = !loaded && out_valid && out_ready;
            gsrc       = 2'd0;
            for (int i = 0; i < 4; i++) if (rr[i]) gsrc = 2'(i);
            gdata = rdata[gsrc];
            if (loaded) begin
                for (int i = 0; i < 4; i++) begin
                    if (rr[i]) begin
                        waits[i] = 0;
                    end else if (req_valid[i]) begin
                        waits[i]++;
                        check("r_fair", {63'd0, (waits[i] <= 3)}, 64'd1);
                    end
                end
            end
            tick();
            if (loaded) begin
                check("r_out_valid", {63'd0, out_valid}, 64'd1);
                check("r_out_data", out_data, gdata);
                check("r_out_src", {62'd0, out_src}, {62'd0, gsrc});
            end else if (drain_only) begin
                check("r_drain", {63'd0, out_valid}, 64'd0);
            end
            // Hold pending requests; re-roll those just accepted or idle
            for (int i = 0; i < 4; i++) begin
                if (rr[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    rdata[i]     = {$urandom, $urandom};
                    if (!req_valid[i]) waits[i] = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
